// File: rtl/noise_lfsr_multi_pkg.sv
// Shared noise definitions: default LFSR seed, feedback taps and the
// refresh engine state encoding, reused by other noise blocks.
package noise_lfsr_multi_pkg;

    localparam int          DEF_LFSR_W = 61;
    localparam logic [60:0] DEF_SEED   = 61'h0C2887F2CB7DB6FE;
    localparam int          DEF_TAP_A  = 60;
    localparam int          DEF_TAP_B  = 59;
    localparam int          DEF_TAP_C  = 45;
    localparam int          DEF_TAP_D  = 44;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/noise_lfsr_multi_step.sv
// One combinational Fibonacci LFSR step with a lock-up guard: an all-zero
// register shifts in a 1 so it can never stay stuck at zero.
module noise_lfsr_step #(
    parameter int LFSR_W = 61,
    parameter int TAP_A  = 60,
    parameter int TAP_B  = 59,
    parameter int TAP_C  = 45,
    parameter int TAP_D  = 44
) (
    input  logic [LFSR_W-1:0] sr,
    output logic [LFSR_W-1:0] sr_next
);

    logic fb;

    always_comb begin
        fb = sr[TAP_A] ^ sr[TAP_B] ^ sr[TAP_C] ^ sr[TAP_D];
        if (sr == '0) begin
            fb = 1'b1;
        end
        sr_next = {sr[LFSR_W-2:0], fb};
    end

endmodule

// File: rtl/noise_lfsr_multi.sv
// Multi-channel noise source: one shared LFSR step engine walks every channel
// DSZ times per refresh, then publishes all channel slices at once.
module noise_lfsr_multi
    import noise_lfsr_multi_pkg::*;
#(
    parameter int                LFSR_W   = DEF_LFSR_W,
    parameter int                DSZ      = 18,
    parameter int                CHANNELS = 4,
    parameter int                TAP_A    = DEF_TAP_A,
    parameter int                TAP_B    = DEF_TAP_B,
    parameter int                TAP_C    = DEF_TAP_C,
    parameter int                TAP_D    = DEF_TAP_D,
    parameter logic [LFSR_W-1:0] SEED     = LFSR_W'(DEF_SEED)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    seed_load,
    output logic [CHANNELS*DSZ-1:0] out,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun,
    output state_t                  dbg_state
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = (DSZ > 1) ? $clog2(DSZ) : 1;

    if (TAP_A >= LFSR_W || TAP_B >= LFSR_W || TAP_C >= LFSR_W || TAP_D >= LFSR_W) begin : g_bad_tap
        $error("noise_lfsr_multi: feedback tap index out of range for LFSR_W");
    end
    if (DSZ > LFSR_W) begin : g_bad_dsz
        $error("noise_lfsr_multi: DSZ must not exceed LFSR_W");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("noise_lfsr_multi: CHANNELS must be at least 1");
    end

    // Handshake: ena and seed_load are single-cycle pulses sampled on the
    // rising edge; seed_load has priority and ena is only accepted in IDLE.
    // out is valid exactly in the cycle out_valid is high and holds afterwards.

    state_t             state;
    logic [CH_W-1:0]    ch;
    logic [CNT_W-1:0]   cnt;
    logic [LFSR_W-1:0]  sr       [CHANNELS];
    logic [LFSR_W-1:0]  seed_rot [CHANNELS];
    logic [LFSR_W-1:0]  eng_in;
    logic [LFSR_W-1:0]  eng_out;
    logic [CHANNELS*DSZ-1:0] out_next;

    // Each channel starts from the base seed rotated left by its index.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_seed
        localparam int ROT = k % LFSR_W;
        if (ROT == 0) begin : g_plain
            assign seed_rot[k] = SEED;
        end else begin : g_rot
            assign seed_rot[k] = (SEED << ROT) | (SEED >> (LFSR_W - ROT));
        end
    end

    assign eng_in = sr[ch];

    noise_lfsr_step #(
        .LFSR_W (LFSR_W),
        .TAP_A  (TAP_A),
        .TAP_B  (TAP_B),
        .TAP_C  (TAP_C),
        .TAP_D  (TAP_D)
    ) u_step (
        .sr      (eng_in),
        .sr_next (eng_out)
    );

    // The last channel's final shift lands on the publishing edge, so its
    // slice comes straight from the engine output.
    always_comb begin
        out_next = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (k == CHANNELS - 1) begin
                out_next[k*DSZ +: DSZ] = eng_out[DSZ-1:0];
            end else begin
                out_next[k*DSZ +: DSZ] = sr[k][DSZ-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ch        <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            out       <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                sr[k] <= seed_rot[k];
            end
        end else begin
            out_valid <= 1'b0;
            if (seed_load) begin
                state   <= ST_IDLE;
                ch      <= '0;
                cnt     <= '0;
                busy    <= 1'b0;
                overrun <= 1'b0;
                for (int k = 0; k < CHANNELS; k++) begin
                    sr[k] <= seed_rot[k];
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ena) begin
                            state <= ST_SHIFT;
                            busy  <= 1'b1;
                            ch    <= '0;
                            cnt   <= CNT_W'(DSZ - 1);
                        end
                    end
                    ST_SHIFT: begin
                        if (ena) begin
                            overrun <= 1'b1;
                        end
                        sr[ch] <= eng_out;
                        if (cnt == '0) begin
                            if (ch == CH_W'(CHANNELS - 1)) begin
                                state     <= ST_IDLE;
                                busy      <= 1'b0;
                                out_valid <= 1'b1;
                                out       <= out_next;
                            end else begin
                                ch  <= ch + 1'b1;
                                cnt <= CNT_W'(DSZ - 1);
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: doc/noise_lfsr_multi.md
NOISE_LFSR_MULTI -- requirements
Module: noise_lfsr_multi

Interface
REQ-001 SHALL have parameter LFSR_W, default 61: LFSR length in bits.
REQ-002 SHALL have parameter DSZ, default 18: output bits per channel, and LFSR steps per channel per refresh.
REQ-003 SHALL have parameter CHANNELS, default 4: number of independent noise channels.
REQ-004 SHALL have parameters TAP_A/TAP_B/TAP_C/TAP_D, defaults 60/59/45/44: feedback bit indices.
REQ-005 SHALL have parameter SEED, default 61'h0C2887F2CB7DB6FE: nonzero base seed.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port ena, input, 1 bit: refresh request, one-cycle pulse.
REQ-009 SHALL have port seed_load, input, 1 bit: reseed request, one-cycle pulse.
REQ-010 SHALL have port out, output, CHANNELS*DSZ bits: channel k occupies bits [k*DSZ +: DSZ].
REQ-011 SHALL have port out_valid, output, 1 bit: one-cycle pulse that coincides with the out update.
REQ-012 SHALL have port busy, output, 1 bit: high while a refresh is running.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag for an ena received while busy.

Function
REQ-014 SHALL keep one LFSR_W register per channel and advance it with sr <= {sr[LFSR_W-2:0], fb}, where fb = sr[TAP_A]^sr[TAP_B]^sr[TAP_C]^sr[TAP_D].
REQ-015 SHALL force fb to 1 whenever the register being shifted is all zero (lock-up guard).
REQ-016 SHALL use one shared shift engine, time-multiplexed across channels, with FSM states IDLE and SHIFT.
REQ-017 In IDLE, ena with seed_load low SHALL move the FSM to SHIFT with ch=0 and cnt=DSZ-1.
REQ-018 In SHIFT, each cycle SHALL shift channel ch once and decrement cnt.
REQ-019 In SHIFT, when cnt==0: if ch<CHANNELS-1, ch SHALL increment and cnt SHALL reload to DSZ-1; otherwise the FSM SHALL return to IDLE.
REQ-020 Timing: ena sampled at edge E0 SHALL raise busy after E0, and SHIFT SHALL occupy edges E1..E(DSZ*CHANNELS).
REQ-021 At edge E(DSZ*CHANNELS), all out slices SHALL update together from bits [DSZ-1:0] of each channel's post-shift register, and out_valid SHALL be high for exactly the following cycle.
REQ-022 busy SHALL fall at that same edge, so a new ena in the out_valid cycle is accepted.
REQ-023 out SHALL hold its value between refreshes; no partial updates are visible.
REQ-024 ena while busy SHALL be ignored and SHALL set overrun; overrun clears only on reset or seed_load.
REQ-025 seed_load in any state SHALL load channel k with SEED rotated left by k mod LFSR_W.
REQ-026 seed_load SHALL abort any running refresh, return the FSM to IDLE, produce no out_valid, leave out unchanged and clear overrun.
REQ-027 When seed_load and ena are high together, seed_load SHALL win, ena SHALL be dropped, and overrun SHALL not be set.
REQ-028 Elaboration SHALL fail if any tap >= LFSR_W, if DSZ > LFSR_W, or if CHANNELS < 1.

Reset
REQ-029 rst_n low SHALL immediately clear out, out_valid, busy and overrun to 0, set the FSM to IDLE with ch=0 and cnt=0, and load channel registers as in REQ-025.
REQ-030 Reset asserted mid-refresh SHALL abandon the refresh with no out_valid after release.
REQ-031 The first ena after rst_n deasserts SHALL behave as REQ-017.

Structure
REQ-032 Default SEED, default taps and the FSM state encodings SHALL live in the shared noise definitions include, for reuse by other noise blocks.
REQ-033 A single sub-module, noise_lfsr_step (combinational: sr in, next sr out, parametrised by LFSR_W and taps, includes the lock-up guard), SHALL be instantiated once, on the shared engine.
REQ-034 The block SHALL contain no filtering; downstream filters consume out qualified by out_valid.

Verification
REQ-035 With LFSR_W=8, DSZ=4, CHANNELS=2, taps 7/5/4/3, SEED=8'h01: reset, one ena -> busy high 8 cycles, then out=8'h31 with a single out_valid pulse.
REQ-036 Same configuration, ena pulsed on cycle 3 of busy -> overrun=1, out=8'h31, exactly one out_valid pulse; a subsequent seed_load -> overrun=0.
REQ-037 seed_load asserted at cycle 5 of a refresh -> busy drops next cycle, no out_valid, out unchanged; the next ena again yields 8'h31.
REQ-038 ena and seed_load asserted together in IDLE -> registers reseeded, busy stays 0, overrun stays 0.
REQ-039 rst_n pulsed low mid-refresh -> all outputs read 0 asynchronously; after release, ena yields 8'h31.
REQ-040 Default parameters, 1000 back-to-back refreshes (ena in each out_valid cycle) -> no overrun, no all-zero channel, output compared against a bit-exact reference model.
